// File: rtl/johnson_seq_counter.sv
// Johnson (twisted-ring) counter, 2*WIDTH states: enable, up/down, clear, indexed load, index decode, tc/err flags.
// Latency: count/err update one edge after the inputs are sampled, idx/tc are combinational from count; no backpressure.
module johnson_seq_counter #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           en,
  input  logic                           dir,
  input  logic                           load,
  input  logic [$clog2(2*WIDTH)-1:0]     load_idx,
  output logic [WIDTH-1:0]               count,
  output logic [$clog2(2*WIDTH)-1:0]     idx,
  output logic                           tc,
  output logic                           err
);

  localparam int IDXW   = $clog2(2*WIDTH);
  localparam int SEQLEN = 2*WIDTH;

  // Index i fills ones from the LSB for i<=WIDTH, then clears them from the LSB.
  function automatic logic [WIDTH-1:0] pattern(input int i);
    logic [WIDTH-1:0] p;
    for (int b = 0; b < WIDTH; b++) begin
      p[b] = (i <= WIDTH) ? (b < i) : (b >= i - WIDTH);
    end
    return p;
  endfunction

  logic             legal;
  logic             load_ok;
  logic [WIDTH-1:0] nxt_up;
  logic [WIDTH-1:0] nxt_dn;

  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int i = 0; i < SEQLEN; i++) begin
      if (count == pattern(i)) begin
        legal = 1'b1;
        idx   = IDXW'(i);
      end
    end
  end

  assign nxt_up  = {count[WIDTH-2:0], ~count[WIDTH-1]};
  assign nxt_dn  = {~count[0], count[WIDTH-1:1]};
  assign load_ok = (int'(load_idx) < SEQLEN);

  assign tc = ~rst & en & ~clr & ~load & legal &
              (dir ? (idx == IDXW'(SEQLEN-1)) : (idx == '0));

  // Illegal-state recovery outranks every control so a corrupted ring never persists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
      err   <= 1'b0;
    end else if (!legal) begin
      count <= '0;
      err   <= 1'b1;
    end else if (clr) begin
      count <= '0;
      err   <= 1'b0;
    end else if (load) begin
      if (load_ok) begin
        count <= pattern(int'(load_idx));
        err   <= 1'b0;
      end else begin
        err   <= 1'b1;
      end
    end else if (en) begin
      count <= dir ? nxt_up : nxt_dn;
      err   <= 1'b0;
    end else begin
      err   <= 1'b0;
    end
  end

endmodule
